// File: rtl/led_matrix_scanner_if.sv
// Frame-producer <-> scanner signal bundle; the brightness input exists only
// when LED_MATRIX_SCANNER_BRIGHTNESS_EN is defined.
interface led_matrix_scanner_if #(
   parameter int ROWS = 5,
   parameter int COLS = 5
);
   logic                 ena;
   logic [ROWS*COLS-1:0] cells;
   logic                 load;
   logic [ROWS-1:0]      rows;
   logic [COLS-1:0]      cols;
   logic                 frame_done;
   logic                 pending;
`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
   logic [3:0]           brightness;

   modport master (output ena, cells, load, brightness,
                   input  rows, cols, frame_done, pending);
   modport slave  (input  ena, cells, load, brightness,
                   output rows, cols, frame_done, pending);
`else
   modport master (output ena, cells, load,
                   input  rows, cols, frame_done, pending);
   modport slave  (input  ena, cells, load,
                   output rows, cols, frame_done, pending);
`endif
endinterface

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed, double-buffered LED matrix scanner with blanking.
// Optional PWM brightness per column: define LED_MATRIX_SCANNER_BRIGHTNESS_EN.
module led_matrix_scanner #(
   parameter int ROWS        = 5,
   parameter int COLS        = 5,
   parameter int DRIVE_TICKS = 1000,
   parameter int BLANK_TICKS = 2
) (
   input  logic                clk,
   input  logic                rst,
   led_matrix_scanner_if.slave bus
);
   localparam int N    = ROWS * COLS;
   localparam int MAXT = (DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS;
   localparam int TW   = (MAXT > 1) ? $clog2(MAXT + 1) : 1;
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [TW-1:0] DRV_LAST = TW'(DRIVE_TICKS - 1);
   localparam logic [TW-1:0] BLK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   col, col_n;
   logic [TW-1:0]   tick, tick_n;
   logic [N-1:0]    disp, disp_n, pbuf, pbuf_n;
   logic            pend, pend_n;
   logic [ROWS-1:0] rows_q, rows_n;
   logic [COLS-1:0] cols_q, cols_n;
   logic            fd_q, fd_n;
   logic            lit;
`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
   logic [3:0]      br, br_n;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         col    <= '0;
         tick   <= '0;
         disp   <= '0;
         pbuf   <= '0;
         pend   <= 1'b0;
         rows_q <= '1;
         cols_q <= '0;
         fd_q   <= 1'b0;
`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
         br     <= '0;
`endif
      end else begin
         state  <= state_n;
         col    <= col_n;
         tick   <= tick_n;
         disp   <= disp_n;
         pbuf   <= pbuf_n;
         pend   <= pend_n;
         rows_q <= rows_n;
         cols_q <= cols_n;
         fd_q   <= fd_n;
`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
         br     <= br_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      col_n   = col;
      tick_n  = tick;
      disp_n  = disp;
      pbuf_n  = pbuf;
      pend_n  = pend;
      if (bus.load) begin
         pbuf_n = bus.cells;
         pend_n = 1'b1;
      end
      if (!bus.ena) begin
         state_n = IDLE;
         col_n   = '0;
         tick_n  = '0;
      end else begin
         case (state)
            IDLE: begin
               col_n   = '0;
               tick_n  = '0;
               state_n = (BLANK_TICKS == 0) ? DRIVE : BLANK;
            end
            BLANK: begin
               if (tick == BLK_LAST) begin
                  tick_n  = '0;
                  state_n = DRIVE;
               end else tick_n = tick + TW'(1);
            end
            DRIVE: begin
               if (tick == DRV_LAST) begin
                  tick_n  = '0;
                  state_n = (BLANK_TICKS == 0) ? DRIVE : BLANK;
                  if (col == COL_LAST) begin
                     // Frame boundary: the only place the display buffer changes.
                     col_n  = '0;
                     pend_n = 1'b0;
                     if (bus.load)  disp_n = bus.cells;
                     else if (pend) disp_n = pbuf;
                  end else col_n = col + CW'(1);
               end else tick_n = tick + TW'(1);
            end
            default: state_n = IDLE;
         endcase
      end

`ifdef LED_MATRIX_SCANNER_BRIGHTNESS_EN
      br_n = br;
      if (state_n == DRIVE && tick_n == '0) br_n = bus.brightness;
      // tick < ceil(D*b/15)  <=>  tick*15 < D*b
      lit = (int'(tick_n) * 15) < (DRIVE_TICKS * int'(br_n));
`else
      lit = 1'b1;
`endif

      // Outputs are decoded from next state so they come straight off flops.
      rows_n = '1;
      cols_n = '0;
      fd_n   = 1'b0;
      if (state_n == DRIVE) begin
         fd_n = (col_n == COL_LAST) && (tick_n == DRV_LAST);
         if (lit) begin
            cols_n[col_n] = 1'b1;
            for (int r = 0; r < ROWS; r++)
               rows_n[r] = ~disp_n[r*COLS + int'(col_n)];
         end
      end
   end

   assign bus.rows       = rows_q;
   assign bus.cols       = cols_q;
   assign bus.frame_done = fd_q;
   assign bus.pending    = pend;
endmodule
